// File: rtl/apb_pkg.sv
// apb_pkg
//   Shared APB definitions: bus-phase state type, default completer window
//   base, the ID word reported by register 0, and the window-hit helper used
//   by the completer's address decode.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

    localparam logic [31:0] SLAVE_ADDR = 32'h0000_A000;
    localparam logic [31:0] ID_VALUE   = 32'hA5B0_0001;

    // Word-aligned address inside [base, base + 4*nregs).
    function automatic logic apb_hit(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned nregs);
        logic [31:0] w_limit;
        w_limit = base + 32'(4 * nregs);
        return (addr >= base) && (addr < w_limit) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/apb_regfile.sv
// apb_regfile
//   NUM_REGS x 32-bit register bank. Register 0 is a hardwired ID word,
//   registers 1..NUM_REGS-1 are writable and clear on reset.
// Ports
//   i_clk    in   1       clock, rising edge
//   i_rst_n  in   1       asynchronous active-low reset
//   i_we     in   1       write strobe (ignored for index 0)
//   i_idx    in   IDX_W   register index for both ports
//   i_wdata  in   32      write data
//   o_rdata  out  32      combinational read data (0 for indices >= NUM_REGS)
module apb_regfile
    import apb_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_regs [1:NUM_REGS-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (i_idx == IDX_W'(i)) begin
                    r_regs[i] <= i_wdata;
                end
            end
        end
    end

    // Loop-based mux keeps non-power-of-two banks safe: unmatched indices read 0.
    always_comb begin
        o_rdata = '0;
        if (i_idx == '0) begin
            o_rdata = ID_VALUE;
        end
        for (int i = 1; i < NUM_REGS; i++) begin
            if (i_idx == IDX_W'(i)) begin
                o_rdata = r_regs[i];
            end
        end
    end

endmodule

// File: rtl/apb_completer_regs.sv
// apb_completer_regs
//   APB completer with a small register bank at BASE_ADDR. Inserts
//   WAIT_STATES pready-low ACCESS cycles per transfer and raises pslverr on
//   out-of-window, misaligned or read-only (ID) accesses.
// Ports
//   pclk      in   1    bus clock
//   preset_n  in   1    asynchronous active-low reset
//   psel      in   1    completer select
//   penable   in   1    ACCESS phase indicator
//   pwrite    in   1    1 = write, 0 = read
//   paddr     in   32   byte address
//   pwdata    in   32   write data
//   prdata    out  32   read data, nonzero only in the completion cycle
//   pready    out  1    completion strobe
//   pslverr   out  1    error response, only in the completion cycle
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | no transfer seen last cycle (idle, abort, or finished)
// ST_SETUP  | last cycle was a SETUP phase (psel & !penable)
// ST_ACCESS | last cycle was an ACCESS phase (psel & penable)
module apb_completer_regs
    import apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = SLAVE_ADDR,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_STATES = 2
) (
    input  logic        pclk,
    input  logic        preset_n,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);

    localparam int IDX_W = $clog2(NUM_REGS);

    apb_state_t       r_state;
    apb_state_t       w_state_nxt;
    logic [3:0]       r_count;
    logic             w_setup;
    logic             w_access;
    logic             w_done;
    logic             w_hit;
    logic [IDX_W-1:0] w_idx;
    logic             w_we;
    logic [31:0]      w_rdata;

    assign w_setup  = psel & ~penable;
    assign w_access = psel & penable;
    // Gated by preset_n so outputs drop in the same cycle reset is asserted.
    assign w_done   = preset_n & w_access & (r_count == 4'd0);

    assign w_hit = apb_hit(paddr, BASE_ADDR, NUM_REGS);
    assign w_idx = IDX_W'((paddr - BASE_ADDR) >> 2);

    // Wait counter: reloads on every SETUP, counts down through ACCESS, saturates at 0.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_count <= 4'd0;
        end else if (w_setup) begin
            r_count <= 4'(WAIT_STATES);
        end else if (w_access && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_setup) w_state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                if (w_access)   w_state_nxt = ST_ACCESS;
                else if (!psel) w_state_nxt = ST_IDLE;
            end
            ST_ACCESS: begin
                // Completion followed directly by a new SETUP goes straight back to SETUP.
                if (w_setup)       w_state_nxt = ST_SETUP;
                else if (w_access) w_state_nxt = ST_ACCESS;
                else               w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pready  = 1'b0;
        prdata  = '0;
        pslverr = 1'b0;
        w_we    = 1'b0;
        if (w_done) begin
            pready = 1'b1;
            if (pwrite) begin
                if (w_hit && (w_idx != '0)) w_we    = 1'b1;
                else                        pslverr = 1'b1;
            end else begin
                if (w_hit) prdata  = w_rdata;
                else       pslverr = 1'b1;
            end
        end
    end

    apb_regfile #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .i_clk   (pclk),
        .i_rst_n (preset_n),
        .i_we    (w_we),
        .i_idx   (w_idx),
        .i_wdata (pwdata),
        .o_rdata (w_rdata)
    );

endmodule

// File: tb/tb_apb_completer_regs.sv
module tb_apb_completer_regs;

    localparam int          NREG = 8;
    localparam logic [31:0] BASE = 32'h0000_A000;
    localparam logic [31:0] IDV  = 32'hA5B0_0001;

    logic        pclk = 1'b0;
    logic        preset_n = 1'b0;
    logic        psel0 = 1'b0, psel1 = 1'b0;
    logic        penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, pslverr0, pslverr1;

    int total = 0;
    int bad   = 0;

    // Reference register contents, one bank per DUT (index 0 unused: ID).
    logic [31:0] model [2][NREG];
    int          nwait_exp [2] = '{2, 0};

    always #5 pclk = ~pclk;

    apb_completer_regs #(.BASE_ADDR(BASE), .NUM_REGS(NREG), .WAIT_STATES(2)) dut0 (
        .pclk(pclk), .preset_n(preset_n), .psel(psel0), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0));

    apb_completer_regs #(.BASE_ADDR(BASE), .NUM_REGS(NREG), .WAIT_STATES(0)) dut1 (
        .pclk(pclk), .preset_n(preset_n), .psel(psel1), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata1), .pready(pready1), .pslverr(pslverr1));

    // Address must hold steady across an unfinished ACCESS phase.
    logic [31:0] prev_addr = '0;
    logic        prev_open = 1'b0;
    always @(posedge pclk) begin
        if (preset_n && (psel0 || psel1) && penable && prev_open)
            assert (paddr == prev_addr) else $error("paddr changed during ACCESS");
        prev_open <= preset_n && (psel0 || psel1) && penable &&
                     !(psel0 ? pready0 : pready1);
        prev_addr <= paddr;
    end

    function automatic void model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NREG; i++) model[d][i] = '0;
    endfunction

    // Applies one transfer to the reference model and returns the expected response.
    function automatic void model_apply(input int d, input bit wr, input logic [31:0] a,
                                        input logic [31:0] wd,
                                        output logic [31:0] exp_rd, output logic exp_err);
        bit hit;
        int idx;
        hit = (a >= BASE) && (a < BASE + 4 * NREG) && (a % 4 == 0);
        idx = hit ? int'((a - BASE) / 4) : 0;
        exp_rd  = '0;
        exp_err = 1'b0;
        if (wr) begin
            if (hit && idx != 0) model[d][idx] = wd;
            else                 exp_err = 1'b1;
        end else begin
            if (!hit)          exp_err = 1'b1;
            else if (idx == 0) exp_rd = IDV;
            else               exp_rd = model[d][idx];
        end
    endfunction

    // Starts at posedge+1 with the SETUP phase; returns at posedge+1 after completion.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int nw);
        psel0 = (d == 0); psel1 = (d == 1);
        penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        @(posedge pclk); #1 penable = 1'b1;
        nw = -1; rd = '0; err = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge pclk);
            if (d == 0 ? pready0 : pready1) begin
                rd  = (d == 0) ? prdata0 : prdata1;
                err = (d == 0) ? pslverr0 : pslverr1;
                nw  = c;
                @(posedge pclk); #1;
                break;
            end
            total++;
            if (((d == 0) ? prdata0 : prdata1) !== 32'h0 || ((d == 0) ? pslverr0 : pslverr1) !== 1'b0) begin
                bad++;
                $display("FAIL wait_quiet dut%0d addr=%h: prdata=%h pslverr=%b, want 0/0",
                         d, a, (d == 0) ? prdata0 : prdata1, (d == 0) ? pslverr0 : pslverr1);
            end
            @(posedge pclk); #1;
        end
        if (nw < 0) begin
            total++; bad++;
            $display("FAIL pready_timeout dut%0d addr=%h: no pready within 20 cycles", d, a);
        end
    endtask

    task automatic idle();
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic err; int nw;
        preset_n = 1'b0;
        psel1 = 1'b1; penable = 1'b1;   // would complete instantly if reset did not gate it
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        total++;
        if ({pready0, pready1, pslverr0, pslverr1} !== 4'b0 || prdata0 !== 0 || prdata1 !== 0) begin
            bad++;
            $display("FAIL reset_outputs: pready=%b%b pslverr=%b%b prdata=%h/%h, want all 0",
                     pready0, pready1, pslverr0, pslverr1, prdata0, prdata1);
        end
        psel1 = 1'b0; penable = 1'b0;
        @(posedge pclk); #1 preset_n = 1'b1;
        model_reset();
        idle();
        for (int i = 0; i < NREG; i++) begin
            xfer(0, 1'b0, BASE + 32'(4 * i), '0, rd, err, nw);
            total++;
            if (rd !== ((i == 0) ? IDV : 32'h0) || err !== 1'b0) begin
                bad++;
                $display("FAIL reset_reg%0d: prdata=%h pslverr=%b, want %h/0", i, rd, err,
                         (i == 0) ? IDV : 32'h0);
            end
        end
        idle();
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic err; int nw;
        logic [31:0] exp_rd; logic exp_err;
        xfer(0, 1'b1, 32'hA004, 32'hDEAD_BEEF, rd, err, nw);
        model_apply(0, 1'b1, 32'hA004, 32'hDEAD_BEEF, exp_rd, exp_err);
        total++;
        if (nw !== 2 || err !== 1'b0) begin
            bad++;
            $display("FAIL write_a004: waits=%0d pslverr=%b, want 2/0", nw, err);
        end
        idle();
        xfer(0, 1'b0, 32'hA004, '0, rd, err, nw);
        total++;
        if (rd !== 32'hDEAD_BEEF || err !== 1'b0 || nw !== 2) begin
            bad++;
            $display("FAIL read_a004: prdata=%h pslverr=%b waits=%0d, want deadbeef/0/2", rd, err, nw);
        end
        idle();
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd; logic err; int nw;
        xfer(1, 1'b0, 32'hA000, '0, rd, err, nw);
        total++;
        if (nw !== 0 || rd !== IDV || err !== 1'b0) begin
            bad++;
            $display("FAIL zero_wait_id: waits=%0d prdata=%h pslverr=%b, want 0/%h/0", nw, rd, err, IDV);
        end
        idle();
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int nw;
        logic [31:0] exp_rd; logic exp_err;
        logic [31:0] waddr [3] = '{32'hA000, 32'hA020, 32'hA006};
        logic [31:0] raddr [4] = '{32'hA000, 32'hA020, 32'hA004, 32'hA006};
        for (int i = 0; i < 3; i++) begin
            xfer(0, 1'b1, waddr[i], 32'h5555_0000 + 32'(i), rd, err, nw);
            model_apply(0, 1'b1, waddr[i], 32'h5555_0000 + 32'(i), exp_rd, exp_err);
            total++;
            if (err !== 1'b1 || exp_err !== 1'b1) begin
                bad++;
                $display("FAIL err_write %h: pslverr=%b, want 1", waddr[i], err);
            end
            idle();
        end
        for (int i = 0; i < 4; i++) begin
            xfer(0, 1'b0, raddr[i], '0, rd, err, nw);
            model_apply(0, 1'b0, raddr[i], '0, exp_rd, exp_err);
            total++;
            if (rd !== exp_rd || err !== exp_err) begin
                bad++;
                $display("FAIL err_readback %h: prdata=%h pslverr=%b, want %h/%b",
                         raddr[i], rd, err, exp_rd, exp_err);
            end
            idle();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err; int nw1, nw2;
        logic [31:0] exp_rd; logic exp_err;
        xfer(0, 1'b1, 32'hA008, 32'h1111_1111, rd, err, nw1);
        model_apply(0, 1'b1, 32'hA008, 32'h1111_1111, exp_rd, exp_err);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL b2b_write: pslverr=%b, want 0", err);
        end
        xfer(0, 1'b0, 32'hA008, '0, rd, err, nw2);
        total++;
        if (rd !== 32'h1111_1111 || err !== 1'b0 || nw1 !== 2 || nw2 !== 2) begin
            bad++;
            $display("FAIL b2b_read: prdata=%h pslverr=%b waits=%0d/%0d, want 11111111/0/2/2",
                     rd, err, nw1, nw2);
        end
        idle();
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic err; int nw;
        psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hA00C; pwdata = 32'hCAFE_F00D;
        @(posedge pclk); #1 penable = 1'b1;
        @(negedge pclk);
        total++;
        if (pready0 !== 1'b0) begin
            bad++;
            $display("FAIL abort_access1: pready=%b, want 0", pready0);
        end
        @(posedge pclk); #1 psel0 = 1'b0;
        @(negedge pclk);
        total++;
        if (pready0 !== 1'b0 || pslverr0 !== 1'b0) begin
            bad++;
            $display("FAIL abort_dropped: pready=%b pslverr=%b, want 0/0", pready0, pslverr0);
        end
        idle();
        xfer(0, 1'b0, 32'hA00C, '0, rd, err, nw);
        total++;
        if (rd !== 32'h0 || err !== 1'b0 || nw !== 2) begin
            bad++;
            $display("FAIL abort_readback: prdata=%h pslverr=%b waits=%0d, want 0/0/2", rd, err, nw);
        end
        idle();
    endtask

    task automatic test_random();
        logic [31:0] rd; logic err; int nw;
        logic [31:0] exp_rd; logic exp_err;
        for (int n = 0; n < 60; n++) begin
            int d;
            bit wr;
            logic [31:0] a, wd;
            d  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            a  = BASE - 32'd4 + 32'($urandom_range(0, 44));
            wd = $urandom;
            xfer(d, wr, a, wd, rd, err, nw);
            model_apply(d, wr, a, wd, exp_rd, exp_err);
            total++;
            if (err !== exp_err || nw !== nwait_exp[d] || (!wr && rd !== exp_rd)) begin
                bad++;
                $display("FAIL random#%0d dut%0d %s %h: prdata=%h pslverr=%b waits=%0d, want %h/%b/%0d",
                         n, d, wr ? "wr" : "rd", a, rd, err, nw, exp_rd, exp_err, nwait_exp[d]);
            end
            if ($urandom_range(0, 1) == 0) idle();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err; int nw;
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'hA000;
        @(posedge pclk); #1 penable = 1'b1;
        @(negedge pclk);
        total++;
        if (pready1 !== 1'b1 || prdata1 !== IDV) begin
            bad++;
            $display("FAIL rst_mid_pre: pready=%b prdata=%h, want 1/%h", pready1, prdata1, IDV);
        end
        #1 preset_n = 1'b0;
        #1;
        total++;
        if (pready1 !== 1'b0 || prdata1 !== 32'h0 || pslverr1 !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_outputs: pready=%b prdata=%h pslverr=%b, want 0/0/0",
                     pready1, prdata1, pslverr1);
        end
        psel1 = 1'b0; penable = 1'b0;
        @(posedge pclk); #1 preset_n = 1'b1;
        model_reset();
        idle();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NREG; i++) begin
                xfer(d, 1'b0, BASE + 32'(4 * i), '0, rd, err, nw);
                total++;
                if (rd !== ((i == 0) ? IDV : 32'h0) || err !== 1'b0) begin
                    bad++;
                    $display("FAIL rst_mid_reg dut%0d reg%0d: prdata=%h pslverr=%b, want %h/0",
                             d, i, rd, err, (i == 0) ? IDV : 32'h0);
                end
            end
            idle();
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_wait();
        test_errors();
        test_back_to_back();
        test_abort();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
